pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline hazard and flow controller for the 8-bit pipelined core. It sits beside the IF/ID and ID/EX pipeline registers and drives their stall and flush controls.
- Inserts bubbles on read-after-write hazards, since the core has no forwarding.
- Squashes wrong-path instructions when a branch resolves taken in EX.
- Freezes the front end on an external halt request.

Parameters:
- REG_W, 2, register-index width; rd = instr[2*REG_W-1:REG_W], rs = instr[REG_W-1:0].
- STALL_CYCLES, 2, bubbles inserted per RAW hazard (1..7).
- FLUSH_CYCLES, 1, cycles flush is held after a taken branch (1..3).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- IF_ID_Instr  in  8  instruction in decode.
- ID_EX_Instr  in  8  instruction in execute.
- ID_EX_RegWrite  in  1  EX instruction writes rd.
- ID_EX_PC_sel  in  1  branch taken, resolved in EX.
- halt_req  in  1  external halt request, level.
- resume  in  1  single-cycle release from HALT.
- PC_stall  out  1  hold PC.
- IF_ID_stall  out  1  hold IF/ID register.
- IF_ID_flush  out  1  zero IF/ID register.
- ID_EX_flush  out  1  zero ID/EX register (drives its Flush input).
- ctrl_state  out  2  RUN=0, STALL=1, FLUSH=2, HALT=3.

Behaviour:
- One clock (clk). reset is asynchronous, active-low.
- While reset is low, regardless of clk:
  - state = RUN and counter = 0.
  - All outputs are 0, including outputs that are combinational from state.
- A reset asserted mid-STALL or mid-FLUSH abandons the sequence. No residual stall follows release.
- Hazard detect, combinational, evaluated in RUN only:
  - raw = ID_EX_RegWrite && (rd(ID_EX_Instr) == rs(IF_ID_Instr) || rd(ID_EX_Instr) == rd(IF_ID_Instr)).
  - The rd compare exists because the ISA is two-operand and rd is also a source.
- Priority, highest first: ID_EX_PC_sel > halt_req > raw.

RUN:
- ID_EX_PC_sel=1:
  - IF_ID_flush=1 and ID_EX_flush=1 in the same cycle.
  - If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
- Else halt_req=1: PC_stall=1, IF_ID_stall=1, ID_EX_flush=1; next state HALT.
- Else raw=1:
  - PC_stall=1, IF_ID_stall=1, ID_EX_flush=1 (one bubble this cycle).
  - If STALL_CYCLES>1, go to STALL with cnt=STALL_CYCLES-1; otherwise stay in RUN.
- Else all outputs 0.

STALL:
- PC_stall, IF_ID_stall and ID_EX_flush are held at 1; cnt decrements each cycle.
- At cnt==1, the next state is RUN.
- ID_EX_PC_sel cannot assert here because bubbles are in EX. If it does assert, FLUSH semantics override: flush both registers and go to FLUSH/RUN as from RUN.
- halt_req is sampled only when STALL completes. If it is high then, go to HALT instead of RUN.

FLUSH:
- IF_ID_flush=1 and ID_EX_flush=1; cnt decrements; next state is RUN at cnt==1.
- Stall outputs are 0 so the PC advances to the branch target.

HALT:
- PC_stall=1, IF_ID_stall=1, ID_EX_flush=1.
- Leave to RUN on resume=1. If halt_req is still 1 on that cycle, resume is ignored.
- If resume and halt_req rise in the same cycle while in RUN, halt wins.

General rules:
- Stall and flush of the same register never assert together. IF_ID_flush takes precedence, so IF_ID_stall=0 whenever IF_ID_flush=1.
- The counter is 3 bits and never wraps; it is loaded only on entry to STALL or FLUSH.

Optional Feature:
PIPE_PERF_CNT_EN
- When defined, two extra outputs are added: stall_events[15:0] and flush_events[15:0].
  - stall_events increments once per RAW hazard entry from RUN.
  - flush_events increments once per taken branch.
  - Both counters saturate at 16'hFFFF and clear on reset.
- When undefined, the ports and logic are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - the ctrl_state encoding constants (RUN, STALL, FLUSH, HALT);
  - REG_W;
  - the rd/rs field-extraction functions, also used by the decoder.
- One natural sub-module, hazard_detect: the combinational RAW compare. The FSM stays in pipe_hazard_ctrl.

Test Plan:
- Reset: hold reset=0 for 3 cycles with ID_EX_PC_sel=1 -> all outputs 0 and ctrl_state=0. Release -> RUN.
- RAW hazard: ID_EX_Instr=8'h14 (rd=1), ID_EX_RegWrite=1, IF_ID_Instr=8'h21 (rs=1) -> PC_stall, IF_ID_stall and ID_EX_flush are 1 for exactly 2 cycles, then 0.
- No hazard: same instructions with ID_EX_RegWrite=0 -> no stall. Also IF_ID_Instr=8'h22 with RegWrite=1 -> no stall.
- Branch, FLUSH_CYCLES=1: pulse ID_EX_PC_sel=1 simultaneous with raw=1 -> IF_ID_flush and ID_EX_flush for 1 cycle, PC_stall=0, no STALL entry.
- Halt: halt_req=1 for 5 cycles, then resume pulse with halt_req=0 -> stalls held through HALT, RUN the cycle after resume. A resume issued while halt_req=1 is ignored.
- Reset mid-STALL: assert reset in the first STALL cycle -> outputs 0 immediately. After release -> RUN with no extra bubble.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared state encoding and instruction field helpers
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } ctrl_state_t;

    function automatic logic [REG_W-1:0] get_rd(input logic [7:0] instr);
        return instr[2*REG_W-1:REG_W];
    endfunction

    function automatic logic [REG_W-1:0] get_rs(input logic [7:0] instr);
        return instr[REG_W-1:0];
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// rtl/pipe_hazard_ctrl_hazard_detect.sv - combinational RAW compare between decode and execute
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [7:0] if_id_instr,
    input  logic [7:0] id_ex_instr,
    input  logic       id_ex_reg_write,
    output logic       raw
);

    // Two-operand ISA: the decode rd is also read, so it is compared as a source too.
    assign raw = id_ex_reg_write &&
                 ((get_rd(id_ex_instr) == get_rs(if_id_instr)) ||
                  (get_rd(id_ex_instr) == get_rd(if_id_instr)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/halt controller; PIPE_PERF_CNT_EN adds event counters
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int STALL_CYCLES = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IF_ID_Instr,
    input  logic [7:0] ID_EX_Instr,
    input  logic       ID_EX_RegWrite,
    input  logic       ID_EX_PC_sel,
    input  logic       halt_req,
    input  logic       resume,
    output logic       PC_stall,
    output logic       IF_ID_stall,
    output logic       IF_ID_flush,
    output logic       ID_EX_flush,
    output logic [1:0] ctrl_state
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [15:0] stall_events,
    output logic [15:0] flush_events
`endif
);

    ctrl_state_t state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        raw;
    logic        hold_front;
    logic        flush_both;
    logic        br_take;

    pipe_hazard_ctrl_hazard_detect u_hazard_detect (
        .if_id_instr     (IF_ID_Instr),
        .id_ex_instr     (ID_EX_Instr),
        .id_ex_reg_write (ID_EX_RegWrite),
        .raw             (raw)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hold_front = 1'b0;
        flush_both = 1'b0;
        br_take    = 1'b0;
        case (state)
            RUN: begin
                if (ID_EX_PC_sel) begin
                    br_take = 1'b1;
                end else if (halt_req) begin
                    hold_front = 1'b1;
                    state_nxt  = HALT;
                end else if (raw) begin
                    hold_front = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        state_nxt = STALL;
                        cnt_nxt   = 3'(STALL_CYCLES - 1);
                    end
                end
            end
            STALL: begin
                if (ID_EX_PC_sel) begin
                    br_take = 1'b1;
                end else begin
                    hold_front = 1'b1;
                    if (cnt != 3'd0) cnt_nxt = cnt - 3'd1;
                    // halt_req only matters once the bubble train is done
                    if (cnt <= 3'd1) state_nxt = halt_req ? HALT : RUN;
                end
            end
            FLUSH: begin
                flush_both = 1'b1;
                if (cnt != 3'd0) cnt_nxt = cnt - 3'd1;
                if (cnt <= 3'd1) state_nxt = RUN;
            end
            HALT: begin
                hold_front = 1'b1;
                if (resume && !halt_req) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
        if (br_take) begin
            flush_both = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = 3'(FLUSH_CYCLES - 1);
            end else begin
                state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs are gated by reset since RUN decodes straight from the inputs.
    assign PC_stall    = reset & hold_front;
    assign IF_ID_stall = reset & hold_front & ~flush_both;
    assign IF_ID_flush = reset & flush_both;
    assign ID_EX_flush = reset & (hold_front | flush_both);
    assign ctrl_state  = reset ? state : 2'd0;

`ifdef PIPE_PERF_CNT_EN
    logic stall_hit;
    logic branch_hit;

    assign stall_hit  = (state == RUN) && !ID_EX_PC_sel && !halt_req && raw;
    assign branch_hit = ((state == RUN) || (state == STALL)) && ID_EX_PC_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_events <= 16'd0;
            flush_events <= 16'd0;
        end else begin
            if (stall_hit && (stall_events != 16'hFFFF)) stall_events <= stall_events + 16'd1;
            if (branch_hit && (flush_events != 16'hFFFF)) flush_events <= flush_events + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized checks against a behavioural model
module tb_pipe_hazard_ctrl;

    localparam int SC = 2;
    localparam int FC = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] IF_ID_Instr;
    logic [7:0] ID_EX_Instr;
    logic       ID_EX_RegWrite;
    logic       ID_EX_PC_sel;
    logic       halt_req;
    logic       resume;
    logic       PC_stall;
    logic       IF_ID_stall;
    logic       IF_ID_flush;
    logic       ID_EX_flush;
    logic [1:0] ctrl_state;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_events;
    logic [15:0] flush_events;
`endif

    int errors = 0;
    int checks = 0;
    bit run_chk = 1'b0;

    // model: mode 0=RUN 1=STALL 2=FLUSH 3=HALT, left = cycles remaining in the sequence
    int m_mode = 0;
    int m_left = 0;
    int m_sev  = 0;
    int m_fev  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.STALL_CYCLES(SC), .FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .reset          (reset),
        .IF_ID_Instr    (IF_ID_Instr),
        .ID_EX_Instr    (ID_EX_Instr),
        .ID_EX_RegWrite (ID_EX_RegWrite),
        .ID_EX_PC_sel   (ID_EX_PC_sel),
        .halt_req       (halt_req),
        .resume         (resume),
        .PC_stall       (PC_stall),
        .IF_ID_stall    (IF_ID_stall),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_flush    (ID_EX_flush),
        .ctrl_state     (ctrl_state)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_events   (stall_events),
        .flush_events   (flush_events)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_raw();
        int ex_rd, id_rd, id_rs;
        ex_rd = (int'(ID_EX_Instr) / 4) % 4;
        id_rd = (int'(IF_ID_Instr) / 4) % 4;
        id_rs = int'(IF_ID_Instr) % 4;
        return ID_EX_RegWrite && (ex_rd == id_rs || ex_rd == id_rd);
    endfunction

    // {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, ctrl_state}
    function automatic logic [5:0] model_out();
        bit hold, fl;
        hold = 0;
        fl   = 0;
        if (!reset) return 6'd0;
        if ((m_mode == 0 || m_mode == 1) && ID_EX_PC_sel) fl = 1;
        else if (m_mode == 0) hold = halt_req || model_raw();
        else if (m_mode == 2) fl = 1;
        else hold = 1;
        return {hold, hold, fl, hold | fl, 2'(m_mode)};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode <= 0;
            m_left <= 0;
            m_sev  <= 0;
            m_fev  <= 0;
        end else if ((m_mode == 0 || m_mode == 1) && ID_EX_PC_sel) begin
            m_mode <= (FC > 1) ? 2 : 0;
            m_left <= FC - 1;
            m_fev  <= (m_fev < 65535) ? m_fev + 1 : m_fev;
        end else if (m_mode == 0) begin
            if (halt_req) begin
                m_mode <= 3;
            end else if (model_raw()) begin
                m_sev <= (m_sev < 65535) ? m_sev + 1 : m_sev;
                if (SC > 1) begin
                    m_mode <= 1;
                    m_left <= SC - 1;
                end
            end
        end else if (m_mode == 1 || m_mode == 2) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_mode <= (m_mode == 1 && halt_req) ? 3 : 0;
        end else if (resume && !halt_req) begin
            m_mode <= 0;
        end
    end

    always @(negedge clk) begin
        logic [5:0] e;
        if (run_chk) begin
            e = model_out();
            chk("pc_stall",    int'(PC_stall),    int'(e[5]));
            chk("if_id_stall", int'(IF_ID_stall), int'(e[4]));
            chk("if_id_flush", int'(IF_ID_flush), int'(e[3]));
            chk("id_ex_flush", int'(ID_EX_flush), int'(e[2]));
            chk("ctrl_state",  int'(ctrl_state),  int'(e[1:0]));
            chk("if_id_excl",  int'(IF_ID_stall & IF_ID_flush), 0);
`ifdef PIPE_PERF_CNT_EN
            chk("stall_events", int'(stall_events), m_sev);
            chk("flush_events", int'(flush_events), m_fev);
`endif
        end
    end

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [5:0] exp);
        chk(name, int'({PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, ctrl_state}), int'(exp));
    endtask

    task automatic set_in(input logic pcs, input logic hr, input logic rs,
                          input logic we, input logic [7:0] ex, input logic [7:0] id);
        ID_EX_PC_sel   = pcs;
        halt_req       = hr;
        resume         = rs;
        ID_EX_RegWrite = we;
        ID_EX_Instr    = ex;
        IF_ID_Instr    = id;
    endtask

    initial begin
        reset = 1'b0;
        set_in(1, 0, 0, 1, 8'h14, 8'h21);
        run_chk = 1'b1;
        repeat (3) begin
            settle();
            lit("reset_hold", 6'b0000_00);
            advance();
        end
        reset = 1'b1;
        set_in(0, 0, 0, 0, 8'h00, 8'h00);
        settle(); lit("after_reset", 6'b0000_00); advance();

        set_in(0, 0, 0, 1, 8'h14, 8'h21);
        settle(); lit("raw_c1", 6'b1101_00); advance();
        ID_EX_RegWrite = 1'b0;
        settle(); lit("raw_c2", 6'b1101_01); advance();
        settle(); lit("raw_done", 6'b0000_00); advance();

        set_in(0, 0, 0, 0, 8'h14, 8'h21);
        settle(); lit("no_haz_we0", 6'b0000_00); advance();
        set_in(0, 0, 0, 1, 8'h14, 8'h22);
        settle(); lit("no_haz_22", 6'b0000_00); advance();

        set_in(1, 0, 0, 1, 8'h14, 8'h21);
        settle(); lit("branch", 6'b0011_00); advance();
        set_in(0, 0, 0, 0, 8'h14, 8'h21);
        settle(); lit("branch_after", 6'b0000_00); advance();

        set_in(0, 1, 0, 0, 8'h00, 8'h00);
        settle(); lit("halt_c1", 6'b1101_00); advance();
        for (int i = 2; i <= 5; i++) begin
            resume = (i == 3);
            settle(); lit("halt_hold", 6'b1101_11); advance();
        end
        set_in(0, 0, 1, 0, 8'h00, 8'h00);
        settle(); lit("resume_cyc", 6'b1101_11); advance();
        resume = 1'b0;
        settle(); lit("resumed", 6'b0000_00); advance();

        set_in(0, 0, 0, 1, 8'h14, 8'h21);
        settle(); lit("raw_pre_rst", 6'b1101_00); advance();
        ID_EX_RegWrite = 1'b0;
        reset = 1'b0;
        #1 lit("reset_mid_stall", 6'b0000_00);
        settle(); lit("reset_mid_stall_hold", 6'b0000_00); advance();
        reset = 1'b1;
        settle(); lit("post_reset_run", 6'b0000_00); advance();
        settle(); lit("post_reset_idle", 6'b0000_00); advance();

        repeat (4000) begin
            ID_EX_PC_sel   = ($urandom % 8) == 0;
            if (($urandom % 10) == 0) halt_req = ~halt_req;
            resume         = ($urandom % 5) == 0;
            ID_EX_RegWrite = $urandom % 2;
            ID_EX_Instr    = 8'($urandom);
            IF_ID_Instr    = 8'($urandom);
            reset          = ($urandom % 150) != 0;
            settle();
            advance();
        end

        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
